// File: rtl/param_register_file.sv
// Parameterised register file: two registered read ports, one write port,
// write-first bypass and a one-register-per-cycle background clear sweep.
module param_register_file #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 4,
    parameter int ZERO_REG   = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data_to_write,
    input  logic [ADDR_WIDTH-1:0] reg_to_write,
    input  logic [ADDR_WIDTH-1:0] reg_to_read1,
    input  logic [ADDR_WIDTH-1:0] reg_to_read2,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] data_to_read1,
    output logic [DATA_WIDTH-1:0] data_to_read2,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        IDLE,
        CLEARING
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  write_ok;
    logic                  sweep_done;
    logic [DATA_WIDTH-1:0] read_next1;
    logic [DATA_WIDTH-1:0] read_next2;

    assign sweep_done = (ptr == ADDR_WIDTH'(DEPTH - 1));
    assign write_ok   = enable && load && !busy &&
                        !((ZERO_REG != 0) && (reg_to_write == '0));

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (clear) next_state = CLEARING;
            CLEARING: if (sweep_done) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // The pointer sits at 0 in IDLE, so a new sweep always starts at register 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            ptr   <= '0;
        end else begin
            state <= next_state;
            busy  <= (next_state == CLEARING);
            if (state == CLEARING) ptr <= ptr + ADDR_WIDTH'(1);
            else                   ptr <= '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (write_ok) regs[reg_to_write] <= data_to_write;
            if (state == CLEARING) regs[ptr] <= '0;
        end
    end

    // Read data reflects the array as it will be after this edge.
    always_comb begin
        read_next1 = regs[reg_to_read1];
        if ((ZERO_REG != 0) && (reg_to_read1 == '0))
            read_next1 = '0;
        else if (write_ok && (reg_to_read1 == reg_to_write))
            read_next1 = data_to_write;
        else if ((state == CLEARING) && (reg_to_read1 == ptr))
            read_next1 = '0;
    end

    always_comb begin
        read_next2 = regs[reg_to_read2];
        if ((ZERO_REG != 0) && (reg_to_read2 == '0))
            read_next2 = '0;
        else if (write_ok && (reg_to_read2 == reg_to_write))
            read_next2 = data_to_write;
        else if ((state == CLEARING) && (reg_to_read2 == ptr))
            read_next2 = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_to_read1 <= '0;
            data_to_read2 <= '0;
        end else if (enable) begin
            data_to_read1 <= read_next1;
            data_to_read2 <= read_next2;
        end
    end

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: directed scenarios plus random traffic, checked
// against an array model of both a plain and a ZERO_REG=1 instance.
module tb_param_register_file;

    localparam int DW    = 18;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          load = 1'b0;
    logic          clear = 1'b0;
    logic [DW-1:0] data_to_write = '0;
    logic [AW-1:0] reg_to_write = '0;
    logic [AW-1:0] reg_to_read1 = '0;
    logic [AW-1:0] reg_to_read2 = '0;

    logic [DW-1:0] rd1_n, rd2_n, rd1_z, rd2_z;
    logic          busy_n, busy_z;

    logic [DW-1:0] mem_m [2][DEPTH];
    logic [DW-1:0] exp1 [2];
    logic [DW-1:0] exp2 [2];
    int            sweep_left;
    int            sweep_idx;
    int            tests = 0;
    int            fails = 0;
    int            busy_cnt;

    param_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0)) dut (
        .clock(clock), .reset(reset), .enable(enable), .load(load),
        .data_to_write(data_to_write), .reg_to_write(reg_to_write),
        .reg_to_read1(reg_to_read1), .reg_to_read2(reg_to_read2), .clear(clear),
        .data_to_read1(rd1_n), .data_to_read2(rd2_n), .busy(busy_n)
    );

    param_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut_z (
        .clock(clock), .reset(reset), .enable(enable), .load(load),
        .data_to_write(data_to_write), .reg_to_write(reg_to_write),
        .reg_to_read1(reg_to_read1), .reg_to_read2(reg_to_read2), .clear(clear),
        .data_to_read1(rd1_z), .data_to_read2(rd2_z), .busy(busy_z)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < DEPTH; i++) mem_m[z][i] = '0;
            exp1[z] = '0;
            exp2[z] = '0;
        end
        sweep_left = 0;
        sweep_idx  = 0;
    endtask

    // Reads observe the array as it stands once this edge's write and sweep step land.
    task automatic model_edge();
        for (int z = 0; z < 2; z++) begin
            if (enable && load && sweep_left == 0 && !(z == 1 && reg_to_write == '0))
                mem_m[z][reg_to_write] = data_to_write;
            if (sweep_left > 0) mem_m[z][sweep_idx] = '0;
            if (enable) begin
                exp1[z] = (z == 1 && reg_to_read1 == '0) ? '0 : mem_m[z][reg_to_read1];
                exp2[z] = (z == 1 && reg_to_read2 == '0) ? '0 : mem_m[z][reg_to_read2];
            end
        end
        if (sweep_left > 0) begin
            sweep_left--;
            sweep_idx = (sweep_idx + 1) % DEPTH;
        end else if (clear) begin
            sweep_left = DEPTH;
            sweep_idx  = 0;
        end
    endtask

    task automatic check_output(input string tag);
        check({tag, "/rd1"}, rd1_n, exp1[0]);
        check({tag, "/rd2"}, rd2_n, exp2[0]);
        check_bit({tag, "/busy"}, busy_n, sweep_left > 0);
        check({tag, "/z_rd1"}, rd1_z, exp1[1]);
        check({tag, "/z_rd2"}, rd2_z, exp2[1]);
        check_bit({tag, "/z_busy"}, busy_z, sweep_left > 0);
    endtask

    task automatic apply_stimulus(input logic en, input logic ld, input logic clr,
                                  input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                  input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                                  input string tag);
        enable = en; load = ld; clear = clr;
        reg_to_write = wa; data_to_write = wd;
        reg_to_read1 = ra1; reg_to_read2 = ra2;
        @(posedge clock);
        model_edge();
        #1;
        check_output(tag);
    endtask

    task automatic fill_all(input string tag);
        for (int i = 0; i < DEPTH; i++)
            apply_stimulus(1'b1, 1'b1, 1'b0, AW'(i), DW'($urandom), AW'(i), AW'(DEPTH - 1 - i), tag);
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < DEPTH; i++)
            apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0, AW'(i), AW'(DEPTH - 1 - i), tag);
    endtask

    initial begin
        model_reset();
        #2 reset = 1'b1;
        #1;
        check_output("reset_async");

        // Activity while reset is held must leave no trace.
        enable = 1'b1; load = 1'b1; clear = 1'b1;
        reg_to_write = 4'd3; data_to_write = 18'h15555; reg_to_read1 = 4'd3;
        repeat (2) @(posedge clock);
        #1;
        check_output("reset_hold");
        reset = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0, 4'd3, 4'd0, "post_reset");

        // Write then read register 0, then hold with enable low.
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'd0, 18'h00003, 4'd7, 4'd8, "r33_write");
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0, 4'd0, 4'd0, "r33_read");
        check("r33_rd1_const", rd1_n, 18'h00003);
        check("r33_rd2_const", rd2_n, 18'h00003);
        apply_stimulus(1'b0, 1'b1, 1'b0, 4'd0, 18'h1FFFF, 4'd9, 4'd10, "r33_hold");
        check("r33_hold_const", rd1_n, 18'h00003);

        // Write-first bypass on port 1 while port 2 reads another register.
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'd3, 18'h12345, 4'd1, 4'd2, "r34_pre");
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'd5, 18'h2AAAA, 4'd5, 4'd3, "r34_bypass");
        check("r34_rd1_const", rd1_n, 18'h2AAAA);
        check("r34_rd2_const", rd2_n, 18'h12345);

        // Full clear sweep with dropped writes and an ignored second clear.
        fill_all("r35_fill");
        apply_stimulus(1'b1, 1'b0, 1'b1, '0, '0, 4'd1, 4'd2, "r35_clear");
        busy_cnt = busy_n ? 1 : 0;
        for (int k = 0; k < 18; k++) begin
            apply_stimulus(1'b1, k < 15, k == 4, AW'($urandom), DW'($urandom),
                           AW'($urandom), AW'($urandom), "r35_sweep");
            if (busy_n) busy_cnt++;
        end
        check_int("r35_busy_cycles", busy_cnt, DEPTH);
        read_all("r35_readback");

        // Reset in the middle of a sweep.
        fill_all("r36_fill");
        apply_stimulus(1'b1, 1'b0, 1'b1, '0, '0, 4'd6, 4'd7, "r36_clear");
        for (int k = 0; k < 7; k++)
            apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0, AW'(k + 8), AW'(15 - k), "r36_sweep");
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_output("r36_abort");
        check_bit("r36_busy_const", busy_n, 1'b0);
        @(posedge clock);
        #1 reset = 1'b0;
        read_all("r36_readback");

        // Hardwired register 0 on the ZERO_REG instance.
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'd0, 18'h3FFFF, 4'd0, 4'd0, "r37_write");
        check("r37_z_bypass_const", rd1_z, 18'h00000);
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0, 4'd0, 4'd0, "r37_read");
        check("r37_z_read_const", rd2_z, 18'h00000);
        check("r37_n_read_const", rd1_n, 18'h3FFFF);

        // Random traffic.
        for (int k = 0; k < 400; k++)
            apply_stimulus(($urandom % 4) != 0, 1'($urandom), ($urandom % 40) == 0,
                           AW'($urandom), DW'($urandom), AW'($urandom), AW'($urandom),
                           "random");
        read_all("final_readback");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/param_register_file.md
PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 The block SHALL have a parameter DATA_WIDTH, default 18, giving the width of each register word.
REQ-002 The block SHALL have a parameter ADDR_WIDTH, default 4, giving the address width; the register count is DEPTH = 2**ADDR_WIDTH.
REQ-003 The block SHALL have a parameter ZERO_REG, default 0; when it is 1, register 0 is hardwired to zero.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Port clock: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 Port reset: input, 1 bit, asynchronous, active-high reset.
REQ-007 Port enable: input, 1 bit, qualifies reads and writes.
REQ-008 Port load: input, 1 bit, write request, valid only when enable=1.
REQ-009 Port data_to_write: input, DATA_WIDTH bits, write data.
REQ-010 Port reg_to_write: input, ADDR_WIDTH bits, write address.
REQ-011 Port reg_to_read1: input, ADDR_WIDTH bits, read address for port 1.
REQ-012 Port reg_to_read2: input, ADDR_WIDTH bits, read address for port 2.
REQ-013 Port clear: input, 1 bit, single-cycle request to zero all registers.
REQ-014 Port data_to_read1: output, DATA_WIDTH bits, registered read data for port 1.
REQ-015 Port data_to_read2: output, DATA_WIDTH bits, registered read data for port 2.
REQ-016 Port busy: output, 1 bit, registered, high while a clear sweep is in progress.

Function
REQ-017 Reads SHALL have a latency of 1 cycle: at a rising edge with enable=1, each data_to_readN loads the contents of reg_to_readN; with enable=0, both outputs hold their values.
REQ-018 A write SHALL occur at a rising edge when enable=1, load=1 and busy=0, storing data_to_write into reg_to_write.
REQ-019 Write-first bypass: when a write is accepted and reg_to_readN equals reg_to_write at the same edge, data_to_readN SHALL load data_to_write, not the old contents.
REQ-020 Both read ports SHALL be able to address the same register in the same cycle; both receive the identical value.
REQ-021 When ZERO_REG=1, writes to address 0 SHALL be dropped, reads of address 0 SHALL return 0, and the bypass of REQ-019 SHALL NOT apply to address 0.
REQ-022 The FSM SHALL have two states, IDLE and CLEARING, and an ADDR_WIDTH-bit sweep pointer.
REQ-023 IDLE -> CLEARING: clear=1 sampled at a rising edge in IDLE, independent of enable; the pointer is set to 0 and busy goes to 1 at that edge.
REQ-024 In CLEARING, each rising edge SHALL zero the register at the pointer and increment the pointer; the edge that zeroes register DEPTH-1 SHALL return the FSM to IDLE and set busy=0, so busy stays high for exactly DEPTH cycles.
REQ-025 The pointer SHALL wrap from DEPTH-1 to 0 without an overflow flag.
REQ-026 clear=1 while in CLEARING SHALL be ignored; it does not restart or extend the sweep.
REQ-027 Writes requested while busy=1 SHALL be dropped silently, with no queuing.
REQ-028 Reads during CLEARING SHALL remain enabled and return the current array contents; a read of the register being zeroed at the same edge SHALL return 0.
REQ-029 When clear and an accepted write coincide in IDLE, the write SHALL complete at that edge and be overwritten later by the sweep.

Reset
REQ-030 While reset=1, asynchronously: all DEPTH registers are 0, data_to_read1=0, data_to_read2=0, busy=0, FSM=IDLE and pointer=0.
REQ-031 Reset asserted mid-sweep SHALL abort the sweep immediately; after release the block is in IDLE with every register at 0.
REQ-032 No write, read or clear SHALL take effect on the rising edge during which reset is high.

Verification
REQ-033 Write 18'h00003 to register 0, then read it on both ports -> both ports show 18'h00003 one cycle after the read edge; with enable=0 the outputs hold.
REQ-034 Write 18'h2AAAA to register 5 with reg_to_read1=5 at the same edge -> data_to_read1=18'h2AAAA after that edge (bypass); data_to_read2 shows the old contents of its own address.
REQ-035 Fill all 16 registers, pulse clear for one cycle -> busy is high for exactly 16 cycles; writes attempted during busy are dropped; all registers then read 0; a second clear pulse mid-sweep does not extend busy.
REQ-036 Fill the registers, start a clear, assert reset at sweep cycle 7 -> busy=0 and the outputs are 0 immediately; all registers read 0 after release.
REQ-037 With ZERO_REG=1, write 18'h3FFFF to register 0 while reading register 0 -> the read returns 0, and a later read also returns 0.
